// File: rtl/adder_share_arb_pkg.sv
// Shared types and defaults for the shared-adder arbiter.
// Holds the FSM encoding and default datapath widths.
package adder_share_pkg;

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_CALC = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam int W    = 16;
    localparam int NREQ = 4;

    typedef enum logic [1:0] {
        IDLE = ST_IDLE,
        CALC = ST_CALC,
        RESP = ST_RESP
    } state_t;

endpackage

// File: rtl/adder_share_arb_if.sv
// Requester operand and response handshake bundle.
// Master drives operands and response ready; slave is the arbiter.
interface adder_share_arb_if #(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 16
);

    logic [NREQ-1:0]   req_valid;
    logic [NREQ-1:0]   req_ready;
    logic [NREQ*W-1:0] req_a;
    logic [NREQ*W-1:0] req_b;
    logic              rsp_valid;
    logic              rsp_ready;
    logic [W-1:0]      rsp_q;
    logic [IDW-1:0]    rsp_id;

    modport master (
        output req_valid, req_a, req_b, rsp_ready,
        input  req_ready, rsp_valid, rsp_q, rsp_id
    );

    modport slave (
        input  req_valid, req_a, req_b, rsp_ready,
        output req_ready, rsp_valid, rsp_q, rsp_id
    );

endinterface

// File: rtl/adder_share_arb_add16.sv
// The shared 16-bit modulo adder.
// No carry in; carry out of the top bit is dropped.
module add16 (
    input  logic [15:0] a,
    input  logic [15:0] b,
    output logic [15:0] s
);

    assign s = a + b;

endmodule

// File: rtl/adder_share_arb_rr_arbiter.sv
// Combinational round-robin arbiter.
// Search starts at ptr and wraps; NREQ must be a power of two.
module rr_arbiter #(
    parameter int NREQ = 4,
    parameter int IDW  = 2
) (
    input  logic [NREQ-1:0] req,
    input  logic [IDW-1:0]  ptr,
    input  logic            en,
    output logic [NREQ-1:0] gnt,
    output logic [IDW-1:0]  gnt_idx,
    output logic            gnt_any
);

    logic [IDW-1:0] idx;
    logic           found;

    // Scan from farthest to nearest so the closest requester to ptr wins
    always_comb begin
        idx     = '0;
        found   = 1'b0;
        gnt_idx = '0;
        for (int k = NREQ - 1; k >= 0; k--) begin
            idx = ptr + IDW'(k);
            if (req[idx]) begin
                gnt_idx = idx;
                found   = 1'b1;
            end
        end
        gnt_any = en & found;
        gnt     = '0;
        if (gnt_any) gnt[gnt_idx] = 1'b1;
    end

endmodule

// File: rtl/adder_share_arb.sv
// Round-robin sharing of one adder among NREQ requesters.
// Accept -> CALC (registered add) -> RESP, with back-to-back accept.
module adder_share_arb
    import adder_share_pkg::*;
#(
    parameter int NREQ = 4,
    parameter int IDW  = 2,
    parameter int W    = 16
) (
    input  logic             clk,
    input  logic             rst_n,
    adder_share_arb_if.slave bus,
    output logic             busy,
    output logic [15:0]      done_cnt
);

    state_t         state;
    logic [IDW-1:0] ptr;
    logic [IDW-1:0] op_id;
    logic [W-1:0]   op_a;
    logic [W-1:0]   op_b;
    logic [W-1:0]   sel_a;
    logic [W-1:0]   sel_b;
    logic [W-1:0]   sum;
    logic [NREQ-1:0] gnt;
    logic [IDW-1:0] gnt_idx;
    logic           gnt_any;
    logic           accept_en;

    assign accept_en = (state == IDLE) |
                       ((state == RESP) & bus.rsp_ready);

    rr_arbiter #(
        .NREQ (NREQ),
        .IDW  (IDW)
    ) u_arb (
        .req     (bus.req_valid),
        .ptr     (ptr),
        .en      (accept_en),
        .gnt     (gnt),
        .gnt_idx (gnt_idx),
        .gnt_any (gnt_any)
    );

    assign bus.req_ready = rst_n ? gnt : '0;
    assign sel_a = bus.req_a[gnt_idx*W +: W];
    assign sel_b = bus.req_b[gnt_idx*W +: W];
    assign busy  = (state != IDLE);

    add16 u_add (
        .a (op_a),
        .b (op_b),
        .s (sum)
    );

    // Operand capture, pointer update and the IDLE/CALC/RESP sequencer
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state         <= IDLE;
            ptr           <= '0;
            op_a          <= '0;
            op_b          <= '0;
            op_id         <= '0;
            bus.rsp_valid <= 1'b0;
            bus.rsp_q     <= '0;
            bus.rsp_id    <= '0;
            done_cnt      <= '0;
        end else begin
            if (gnt_any) begin
                op_a  <= sel_a;
                op_b  <= sel_b;
                op_id <= gnt_idx;
                ptr   <= gnt_idx + 1'b1;
            end
            unique case (state)
                IDLE: begin
                    if (gnt_any) state <= CALC;
                end
                CALC: begin
                    bus.rsp_q     <= sum;
                    bus.rsp_id    <= op_id;
                    bus.rsp_valid <= 1'b1;
                    state         <= RESP;
                end
                RESP: begin
                    if (bus.rsp_ready) begin
                        done_cnt      <= done_cnt + 16'd1;
                        bus.rsp_valid <= 1'b0;
                        state         <= gnt_any ? CALC : IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_adder_share_arb.sv
// Scoreboard bench for the shared-adder arbiter.
// Accepts push expected sums; response handshakes pop and compare.
module tb_adder_share_arb;
    import adder_share_pkg::*;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int DW = 16;

    typedef struct packed {
        logic [IW-1:0] id;
        logic [DW-1:0] q;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        busy;
    logic [15:0] done_cnt;

    exp_t        sb[$];
    int          n_chk = 0;
    int          n_err = 0;
    logic [15:0] exp_cnt = 16'd0;

    adder_share_arb_if #(.NREQ(N), .IDW(IW), .W(DW)) bus ();

    adder_share_arb #(.NREQ(N), .IDW(IW), .W(DW)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .bus      (bus),
        .busy     (busy),
        .done_cnt (done_cnt)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic set_op(input int i, input logic [15:0] a,
                          input logic [15:0] b);
        bus.req_a[i*DW +: DW] = a;
        bus.req_b[i*DW +: DW] = b;
    endtask

    task automatic wait_rdy(input int idx, input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.req_ready[idx] && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.req_ready[idx]), 32'd1);
    endtask

    task automatic wait_rsp(input string tag);
        int n = 0;
        @(negedge clk);
        while (!bus.rsp_valid && n < 20) begin
            @(negedge clk);
            n++;
        end
        chk(tag, 32'(bus.rsp_valid), 32'd1);
    endtask

    task automatic do_single(input int i, input logic [15:0] a,
                             input logic [15:0] b, input logic [15:0] q);
        @(posedge clk); #1;
        set_op(i, a, b);
        bus.req_valid    = '0;
        bus.req_valid[i] = 1'b1;
        wait_rdy(i, "one_acc");
        @(posedge clk); #1;
        bus.req_valid = '0;
        chk("one_t0_vld", 32'(bus.rsp_valid), 32'd0);
        @(posedge clk); #1;
        chk("one_vld", 32'(bus.rsp_valid), 32'd1);
        chk("one_q", 32'(bus.rsp_q), 32'(q));
        chk("one_id", 32'(bus.rsp_id), 32'(i));
        repeat (3) @(negedge clk);
    endtask

    // Scoreboard: push on accept, pop on response, track done count
    always @(negedge clk) begin
        logic [DW-1:0] s;
        exp_t          e;
        if (rst_n) begin
            chk("cnt", 32'(done_cnt), 32'(exp_cnt));
            chk("rdy_1h", 32'($onehot0(bus.req_ready)), 32'd1);
            for (int i = 0; i < N; i++) begin
                if (bus.req_valid[i] && bus.req_ready[i]) begin
                    s = bus.req_a[i*DW +: DW] + bus.req_b[i*DW +: DW];
                    sb.push_back({IW'(i), s});
                end
            end
            if (bus.rsp_valid && bus.rsp_ready) begin
                if (sb.size() == 0) begin
                    chk("rsp_unexp", 32'd1, 32'd0);
                end else begin
                    e = sb.pop_front();
                    chk("sb_q", 32'(bus.rsp_q), 32'(e.q));
                    chk("sb_id", 32'(bus.rsp_id), 32'(e.id));
                end
                exp_cnt = exp_cnt + 16'd1;
            end
        end
    end

    initial begin
        rst_n         = 1'b0;
        bus.req_valid = '1;
        bus.req_a     = '0;
        bus.req_b     = '0;
        bus.rsp_ready = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_rdy", 32'(bus.req_ready), 32'd0);
        chk("rst_vld", 32'(bus.rsp_valid), 32'd0);
        chk("rst_q", 32'(bus.rsp_q), 32'd0);
        chk("rst_id", 32'(bus.rsp_id), 32'd0);
        chk("rst_cnt", 32'(done_cnt), 32'd0);
        chk("rst_busy", 32'(busy), 32'd0);
        bus.req_valid = '0;
        rst_n = 1'b1;

        // Accept on requester 1, then reset mid-CALC
        @(posedge clk); #1;
        set_op(1, 16'h1111, 16'h2222);
        bus.req_valid = 4'b0010;
        wait_rdy(1, "drop_acc");
        @(posedge clk); #1;
        bus.req_valid = '0;
        chk("drop_busy", 32'(busy), 32'd1);
        chk("drop_calc_vld", 32'(bus.rsp_valid), 32'd0);
        rst_n = 1'b0;
        sb.delete();
        exp_cnt = 16'd0;
        #1;
        chk("drop_rst_vld", 32'(bus.rsp_valid), 32'd0);
        chk("drop_rst_busy", 32'(busy), 32'd0);
        chk("drop_rst_cnt", 32'(done_cnt), 32'd0);
        @(negedge clk);
        rst_n = 1'b1;
        bus.rsp_ready = 1'b1;
        repeat (4) begin
            @(negedge clk);
            chk("drop_no_rsp", 32'(bus.rsp_valid), 32'd0);
        end

        // Fairness: all valid, ptr back at 0 after reset
        @(posedge clk); #1;
        for (int i = 0; i < N; i++)
            set_op(i, 16'h0100 * 16'(i + 1), 16'h0011 * 16'(i + 3));
        bus.req_valid = '1;
        wait_rsp("fair_first");
        for (int k = 0; k < 6; k++) begin
            chk("fair_vld", 32'(bus.rsp_valid), 32'd1);
            chk("fair_id", 32'(bus.rsp_id), 32'(k % N));
            @(negedge clk);
            chk("fair_gap", 32'(bus.rsp_valid), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (6) @(negedge clk);

        do_single(2, 16'h1234, 16'h0FF1, 16'h2225);
        do_single(1, 16'hFFFF, 16'h0001, 16'h0000);
        do_single(3, 16'h8000, 16'h8000, 16'h0000);

        // Backpressure: ptr is 0 after requester 3 was served
        @(posedge clk); #1;
        bus.rsp_ready = 1'b0;
        set_op(0, 16'hA5A5, 16'h0101);
        set_op(3, 16'h7000, 16'h0234);
        bus.req_valid = 4'b1001;
        wait_rsp("bp_first");
        repeat (10) begin
            chk("bp_vld", 32'(bus.rsp_valid), 32'd1);
            chk("bp_q", 32'(bus.rsp_q), 32'h0000A6A6);
            chk("bp_id", 32'(bus.rsp_id), 32'd0);
            chk("bp_rdy", 32'(bus.req_ready), 32'd0);
            @(negedge clk);
        end
        @(posedge clk); #1;
        bus.rsp_ready = 1'b1;
        @(negedge clk);
        chk("bp_rel_vld", 32'(bus.rsp_valid), 32'd1);
        chk("bp_rel_rdy", 32'(bus.req_ready), 32'b1000);
        @(posedge clk); #1;
        bus.req_valid = '0;
        repeat (6) @(negedge clk);

        // Counter wrap from a preloaded 0xFFFF
        @(posedge clk); #2;
        force dut.done_cnt = 16'hFFFF;
        exp_cnt = 16'hFFFF;
        #1;
        release dut.done_cnt;
        do_single(0, 16'h0001, 16'h0002, 16'h0003);
        chk("cnt_wrap", 32'(done_cnt), 32'd0);

        repeat (4) @(negedge clk);
        chk("sb_empty", 32'(sb.size()), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors",
                 n_chk, n_err);
        $finish;
    end

endmodule
